// File: rtl/calc3_sched_pkg.sv
// Shared types, command/response codes and command classification for the
// calc3 per-port issue scheduler.
package calc3_sched_pkg;

  localparam int TAG_W = 2;
  localparam int CNT_W = 10;

  localparam logic [3:0] CMD_NOP   = 4'd0;
  localparam logic [3:0] CMD_ADD   = 4'd1;
  localparam logic [3:0] CMD_SUB   = 4'd2;
  localparam logic [3:0] CMD_SHL   = 4'd5;
  localparam logic [3:0] CMD_SHR   = 4'd6;
  localparam logic [3:0] CMD_STORE = 4'd9;
  localparam logic [3:0] CMD_FETCH = 4'd10;
  localparam logic [3:0] CMD_BRZ   = 4'd12;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [3:0]       reg_t;
  typedef logic [3:0]       cmd_t;
  typedef logic [31:0]      data_t;

  // One scoreboard slot: valid doubles as the busy bit for the tag
  typedef struct packed {
    logic valid;
    logic writes_r1;
    reg_t r1;
  } sb_entry_t;

  typedef struct packed {
    logic reads_d1;
    logic reads_d2;
    logic writes_r1;
    logic serialising;
  } cmd_class_t;

  typedef struct packed {
    cmd_t  cmd;
    reg_t  d1;
    reg_t  d2;
    reg_t  r1;
    data_t data;
    tag_t  tag;
  } req_t;

  typedef struct packed {
    logic       valid;
    tag_t       tag;
    logic [1:0] resp;
    data_t      data;
    logic       timeout;
  } cpl_t;

  // Register usage of a command; anything unrecognised is treated as serialising
  function automatic cmd_class_t cmd_class(input cmd_t cmd);
    cmd_class_t c;
    c = '0;
    case (cmd)
      CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR: begin
        c.reads_d1  = 1'b1;
        c.reads_d2  = 1'b1;
        c.writes_r1 = 1'b1;
      end
      CMD_STORE: c.writes_r1 = 1'b1;
      CMD_FETCH: c.reads_d1  = 1'b1;
      CMD_NOP, CMD_BRZ: c.serialising = 1'b1;
      default:   c.serialising = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/calc3_tag_scoreboard.sv
// Tag bookkeeping: busy bitmap, destination registers, per-tag timeout
// counters, lowest-free allocation, hazard compare and retire arbitration.
module calc3_tag_scoreboard
  import calc3_sched_pkg::*;
#(
  parameter int NUM_TAGS     = 4,
  parameter int TIMEOUT      = 64,
  parameter int HAZARD_CHECK = 1
) (
  input  logic                c_clk,
  input  logic                reset,
  input  logic                alloc_en,
  input  cmd_class_t          alloc_cls,
  input  reg_t                new_d1,
  input  reg_t                new_d2,
  input  reg_t                new_r1,
  input  logic                resp_valid,
  input  tag_t                resp_tag,
  output tag_t                alloc_tag,
  output logic                tag_free,
  output logic                hazard,
  output logic                ser_block,
  output logic [NUM_TAGS-1:0] busy,
  output logic                ret_valid,
  output tag_t                ret_tag,
  output logic                ret_timeout,
  output logic                ret_spurious
);

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);

  sb_entry_t [NUM_TAGS-1:0]            ent_q, ent_d;
  logic      [NUM_TAGS-1:0]            ser_q, ser_d;
  logic      [NUM_TAGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic      [NUM_TAGS-1:0]            to_req;
  logic                                hz;

  // Busy view, timeout requests and lowest-numbered free tag
  always_comb begin
    tag_free  = 1'b0;
    alloc_tag = '0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      busy[t]   = ent_q[t].valid;
      to_req[t] = ent_q[t].valid && (cnt_q[t] >= CNT_LIM);
    end
    for (int t = NUM_TAGS - 1; t >= 0; t--) begin
      if (!ent_q[t].valid) begin
        tag_free  = 1'b1;
        alloc_tag = tag_t'(t);
      end
    end
  end

  // Register hazards of the presented command against in-flight writers
  always_comb begin
    hz = 1'b0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      if (ent_q[t].valid && ent_q[t].writes_r1) begin
        if (alloc_cls.reads_d1  && ent_q[t].r1 == new_d1) hz = 1'b1;
        if (alloc_cls.reads_d2  && ent_q[t].r1 == new_d2) hz = 1'b1;
        if (alloc_cls.writes_r1 && ent_q[t].r1 == new_r1) hz = 1'b1;
      end
    end
    hazard    = (HAZARD_CHECK != 0) && hz;
    ser_block = |(ser_q & busy);
  end

  // One retirement per cycle: a real response beats any pending timeout
  always_comb begin
    ret_valid    = 1'b0;
    ret_tag      = '0;
    ret_timeout  = 1'b0;
    ret_spurious = resp_valid && !ent_q[resp_tag].valid;
    if (resp_valid && ent_q[resp_tag].valid) begin
      ret_valid = 1'b1;
      ret_tag   = resp_tag;
    end else begin
      for (int t = NUM_TAGS - 1; t >= 0; t--) begin
        if (to_req[t]) begin
          ret_valid   = 1'b1;
          ret_tag     = tag_t'(t);
          ret_timeout = 1'b1;
        end
      end
    end
  end

  // Next state: count, retire, then allocate (never the same tag)
  always_comb begin
    ent_d = ent_q;
    ser_d = ser_q;
    cnt_d = cnt_q;
    for (int t = 0; t < NUM_TAGS; t++) begin
      if (ent_q[t].valid && !to_req[t]) cnt_d[t] = cnt_q[t] + CNT_W'(1);
    end
    if (ret_valid) ent_d[ret_tag].valid = 1'b0;
    if (alloc_en) begin
      ent_d[alloc_tag].valid     = 1'b1;
      ent_d[alloc_tag].writes_r1 = alloc_cls.writes_r1;
      ent_d[alloc_tag].r1        = new_r1;
      ser_d[alloc_tag]           = alloc_cls.serialising;
      cnt_d[alloc_tag]           = '0;
    end
  end

  // Scoreboard state; reset drops all in-flight operations
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      ent_q <= '0;
      ser_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      ser_q <= ser_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/calc3_port_sched.sv
// Per-port calc3 issue controller: host handshake, one-cycle request
// register and one-per-cycle completion register around the tag scoreboard.
module calc3_port_sched
  import calc3_sched_pkg::*;
#(
  parameter int NUM_TAGS     = 4,
  parameter int TIMEOUT      = 64,
  parameter int HAZARD_CHECK = 1
) (
  input  logic                c_clk,
  input  logic                reset,
  input  logic                host_valid,
  output logic                host_ready,
  input  logic [3:0]          host_cmd,
  input  logic [3:0]          host_d1,
  input  logic [3:0]          host_d2,
  input  logic [3:0]          host_r1,
  input  logic [31:0]         host_data,
  output logic [3:0]          req_cmd,
  output logic [3:0]          req_d1,
  output logic [3:0]          req_d2,
  output logic [3:0]          req_r1,
  output logic [31:0]         req_data,
  output logic [1:0]          req_tag,
  input  logic [1:0]          out_resp,
  input  logic [1:0]          out_tag,
  input  logic [31:0]         out_data,
  output logic                cpl_valid,
  output logic [1:0]          cpl_tag,
  output logic [1:0]          cpl_resp,
  output logic [31:0]         cpl_data,
  output logic                cpl_timeout,
  output logic [NUM_TAGS-1:0] busy_tags,
  output logic                spurious_err
);

  cmd_class_t host_cls;
  tag_t       alloc_tag, ret_tag;
  logic       tag_free, hazard, ser_block, accept, resp_valid;
  logic       ret_valid, ret_timeout, ret_spurious;
  req_t       req_q, req_d;
  cpl_t       cpl_q, cpl_d;
  logic       spur_q, spur_d;

  assign host_cls   = cmd_class(host_cmd);
  assign resp_valid = (out_resp != RESP_NONE);
  // Ready never looks at host_valid, only at registered state and the command
  assign host_ready = tag_free && !hazard && !ser_block &&
                      !(host_cls.serialising && (busy_tags != '0));
  assign accept     = host_valid && host_ready;

  calc3_tag_scoreboard #(
    .NUM_TAGS     (NUM_TAGS),
    .TIMEOUT      (TIMEOUT),
    .HAZARD_CHECK (HAZARD_CHECK)
  ) u_sb (
    .c_clk        (c_clk),
    .reset        (reset),
    .alloc_en     (accept),
    .alloc_cls    (host_cls),
    .new_d1       (host_d1),
    .new_d2       (host_d2),
    .new_r1       (host_r1),
    .resp_valid   (resp_valid),
    .resp_tag     (out_tag),
    .alloc_tag    (alloc_tag),
    .tag_free     (tag_free),
    .hazard       (hazard),
    .ser_block    (ser_block),
    .busy         (busy_tags),
    .ret_valid    (ret_valid),
    .ret_tag      (ret_tag),
    .ret_timeout  (ret_timeout),
    .ret_spurious (ret_spurious)
  );

  // Request lines carry the accepted command for exactly one cycle
  always_comb begin
    req_d = '0;
    if (accept) begin
      req_d.cmd  = host_cmd;
      req_d.d1   = host_d1;
      req_d.d2   = host_d2;
      req_d.r1   = host_r1;
      req_d.data = host_data;
      req_d.tag  = alloc_tag;
    end
  end

  // Completion strobe; timeouts report RESP_NONE with zero data
  always_comb begin
    cpl_d  = '0;
    spur_d = spur_q | ret_spurious;
    if (ret_valid) begin
      cpl_d.valid   = 1'b1;
      cpl_d.tag     = ret_tag;
      cpl_d.timeout = ret_timeout;
      if (!ret_timeout) begin
        cpl_d.resp = out_resp;
        cpl_d.data = out_data;
      end
    end
  end

  // Output registers
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      req_q  <= '0;
      cpl_q  <= '0;
      spur_q <= 1'b0;
    end else begin
      req_q  <= req_d;
      cpl_q  <= cpl_d;
      spur_q <= spur_d;
    end
  end

  assign req_cmd      = req_q.cmd;
  assign req_d1       = req_q.d1;
  assign req_d2       = req_q.d2;
  assign req_r1       = req_q.r1;
  assign req_data     = req_q.data;
  assign req_tag      = req_q.tag;
  assign cpl_valid    = cpl_q.valid;
  assign cpl_tag      = cpl_q.tag;
  assign cpl_resp     = cpl_q.resp;
  assign cpl_data     = cpl_q.data;
  assign cpl_timeout  = cpl_q.timeout;
  assign spurious_err = spur_q;

endmodule

// File: tb/tb_calc3_port_sched.sv
// Directed bench for calc3_port_sched: handshake, hazards, tag reuse,
// timeout, serialising commands and mid-flight reset.
module tb_calc3_port_sched;
  import calc3_sched_pkg::*;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_valid = 1'b0, host_ready;
  logic [3:0]  host_cmd = '0, host_d1 = '0, host_d2 = '0, host_r1 = '0;
  logic [31:0] host_data = '0;
  logic [3:0]  req_cmd, req_d1, req_d2, req_r1;
  logic [31:0] req_data;
  logic [1:0]  req_tag;
  logic [1:0]  out_resp = '0, out_tag = '0;
  logic [31:0] out_data = '0;
  logic        cpl_valid, cpl_timeout, spurious_err;
  logic [1:0]  cpl_tag, cpl_resp;
  logic [31:0] cpl_data;
  logic [3:0]  busy_tags;

  int n_chk = 0;
  int n_fail = 0;

  calc3_port_sched #(.NUM_TAGS(4), .TIMEOUT(64), .HAZARD_CHECK(1)) dut (
    .c_clk(c_clk), .reset(reset),
    .host_valid(host_valid), .host_ready(host_ready), .host_cmd(host_cmd),
    .host_d1(host_d1), .host_d2(host_d2), .host_r1(host_r1), .host_data(host_data),
    .req_cmd(req_cmd), .req_d1(req_d1), .req_d2(req_d2), .req_r1(req_r1),
    .req_data(req_data), .req_tag(req_tag),
    .out_resp(out_resp), .out_tag(out_tag), .out_data(out_data),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_resp(cpl_resp),
    .cpl_data(cpl_data), .cpl_timeout(cpl_timeout),
    .busy_tags(busy_tags), .spurious_err(spurious_err)
  );

  always #5 c_clk = ~c_clk;

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [3:0] d1,
                       input logic [3:0] d2, input logic [3:0] r1);
    host_valid = 1'b1;
    host_cmd   = cmd;
    host_d1    = d1;
    host_d2    = d2;
    host_r1    = r1;
    host_data  = {28'h0, r1} + 32'h1000;
  endtask

  task automatic idle();
    host_valid = 1'b0;
    host_cmd   = '0;
    host_d1    = '0;
    host_d2    = '0;
    host_r1    = '0;
  endtask

  task automatic do_reset();
    idle();
    out_resp = '0;
    reset    = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (req_cmd !== 4'd0) begin n_fail++; $display("FAIL reset_req_cmd: got %0d want 0", req_cmd); end
    n_chk++; if (busy_tags !== 4'b0000) begin n_fail++; $display("FAIL reset_busy: got %b want 0000", busy_tags); end
    n_chk++; if (cpl_valid !== 1'b0 || spurious_err !== 1'b0) begin n_fail++; $display("FAIL reset_cpl_spur: got %b%b want 00", cpl_valid, spurious_err); end
    drive(CMD_ADD, 4'd1, 4'd2, 4'd3);
    #1;
    n_chk++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", host_ready); end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(CMD_ADD, 4'd1, 4'd2, 4'd3);
    tick();
    n_chk++; if ({req_cmd, req_tag, req_d1, req_d2, req_r1} !== {4'd1, 2'd0, 4'd1, 4'd2, 4'd3}) begin n_fail++; $display("FAIL b2b_first: got %h want %h", {req_cmd, req_tag, req_d1, req_d2, req_r1}, {4'd1, 2'd0, 4'd1, 4'd2, 4'd3}); end
    n_chk++; if (req_data !== 32'h1003) begin n_fail++; $display("FAIL b2b_data: got %h want 00001003", req_data); end
    drive(CMD_SUB, 4'd4, 4'd5, 4'd6);
    tick();
    n_chk++; if ({req_cmd, req_tag} !== {4'd2, 2'd1}) begin n_fail++; $display("FAIL b2b_second: got %h want %h", {req_cmd, req_tag}, {4'd2, 2'd1}); end
    n_chk++; if (busy_tags !== 4'b0011) begin n_fail++; $display("FAIL b2b_busy: got %b want 0011", busy_tags); end
    idle();
    tick();
    n_chk++; if ({req_cmd, req_tag, req_d1, req_r1, req_data} !== 46'd0) begin n_fail++; $display("FAIL b2b_return_zero: got %h want 0", {req_cmd, req_tag, req_d1, req_r1, req_data}); end
  endtask

  task automatic test_hazard();
    do_reset();
    drive(CMD_ADD, 4'd1, 4'd2, 4'd3);
    tick();
    drive(CMD_FETCH, 4'd3, 4'd0, 4'd0);
    #1;
    n_chk++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL hz_stall: got %b want 0", host_ready); end
    tick();
    tick();
    n_chk++; if (host_ready !== 1'b0 || req_cmd !== 4'd0) begin n_fail++; $display("FAIL hz_hold: got ready %b cmd %0d want 0 0", host_ready, req_cmd); end
    out_resp = RESP_OK; out_tag = 2'd0; out_data = 32'hABCD_0123;
    tick();
    out_resp = RESP_NONE;
    n_chk++; if ({cpl_valid, cpl_tag, cpl_resp, cpl_timeout} !== {1'b1, 2'd0, 2'd1, 1'b0}) begin n_fail++; $display("FAIL hz_cpl: got %b want 1000010", {cpl_valid, cpl_tag, cpl_resp, cpl_timeout}); end
    n_chk++; if (cpl_data !== 32'hABCD_0123) begin n_fail++; $display("FAIL hz_cpl_data: got %h want abcd0123", cpl_data); end
    n_chk++; if (req_cmd !== 4'd0 || host_ready !== 1'b1) begin n_fail++; $display("FAIL hz_release: got cmd %0d ready %b want 0 1", req_cmd, host_ready); end
    tick();
    idle();
    n_chk++; if ({req_cmd, req_tag, req_d1, cpl_valid} !== {4'd10, 2'd0, 4'd3, 1'b0}) begin n_fail++; $display("FAIL hz_issue: got %h want %h", {req_cmd, req_tag, req_d1, cpl_valid}, {4'd10, 2'd0, 4'd3, 1'b0}); end
  endtask

  task automatic test_tag_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(CMD_ADD, 4'(3 * i + 1), 4'(3 * i + 2), 4'(3 * i + 3));
      tick();
      n_chk++; if ({req_cmd, req_tag} !== {4'd1, 2'(i)}) begin n_fail++; $display("FAIL full_issue%0d: got %h want %h", i, {req_cmd, req_tag}, {4'd1, 2'(i)}); end
    end
    drive(CMD_ADD, 4'd13, 4'd14, 4'd15);
    #1;
    n_chk++; if (host_ready !== 1'b0 || busy_tags !== 4'b1111) begin n_fail++; $display("FAIL full_block: got ready %b busy %b want 0 1111", host_ready, busy_tags); end
    out_resp = RESP_OK; out_tag = 2'd2;
    tick();
    out_resp = RESP_NONE;
    n_chk++; if (req_cmd !== 4'd0 || busy_tags !== 4'b1011) begin n_fail++; $display("FAIL full_free: got cmd %0d busy %b want 0 1011", req_cmd, busy_tags); end
    tick();
    idle();
    n_chk++; if ({req_cmd, req_tag, req_r1} !== {4'd1, 2'd2, 4'd15} || busy_tags !== 4'b1111) begin n_fail++; $display("FAIL full_reuse: got %h busy %b want %h 1111", {req_cmd, req_tag, req_r1}, busy_tags, {4'd1, 2'd2, 4'd15}); end
  endtask

  task automatic test_timeout();
    int k;
    do_reset();
    drive(CMD_ADD, 4'd1, 4'd2, 4'd3);
    tick();
    idle();
    k = 0;
    while (!cpl_valid && k < 80) begin
      tick();
      k++;
    end
    n_chk++; if (k !== 64) begin n_fail++; $display("FAIL to_latency: got %0d cycles want 64", k); end
    n_chk++; if ({cpl_valid, cpl_timeout, cpl_tag, cpl_resp, cpl_data} !== {1'b1, 1'b1, 2'd0, 2'd0, 32'd0}) begin n_fail++; $display("FAIL to_cpl: got %h want %h", {cpl_valid, cpl_timeout, cpl_tag, cpl_resp, cpl_data}, {1'b1, 1'b1, 2'd0, 2'd0, 32'd0}); end
    n_chk++; if (busy_tags !== 4'b0000) begin n_fail++; $display("FAIL to_busy: got %b want 0000", busy_tags); end
    tick();
    out_resp = RESP_OK; out_tag = 2'd0;
    tick();
    out_resp = RESP_NONE;
    n_chk++; if (spurious_err !== 1'b1 || cpl_valid !== 1'b0) begin n_fail++; $display("FAIL to_late_resp: got spur %b cpl %b want 1 0", spurious_err, cpl_valid); end
  endtask

  task automatic test_collision();
    do_reset();
    drive(CMD_ADD, 4'd1, 4'd2, 4'd3);
    tick();
    drive(CMD_ADD, 4'd4, 4'd5, 4'd6);
    tick();
    idle();
    for (int i = 0; i < 62; i++) tick();
    n_chk++; if (cpl_valid !== 1'b0) begin n_fail++; $display("FAIL col_early: got %b want 0", cpl_valid); end
    out_resp = RESP_ERR; out_tag = 2'd1; out_data = 32'h55;
    tick();
    out_resp = RESP_NONE;
    n_chk++; if ({cpl_valid, cpl_tag, cpl_resp, cpl_timeout, cpl_data} !== {1'b1, 2'd1, 2'd2, 1'b0, 32'h55}) begin n_fail++; $display("FAIL col_resp_first: got %h want %h", {cpl_valid, cpl_tag, cpl_resp, cpl_timeout, cpl_data}, {1'b1, 2'd1, 2'd2, 1'b0, 32'h55}); end
    n_chk++; if (busy_tags !== 4'b0001) begin n_fail++; $display("FAIL col_busy: got %b want 0001", busy_tags); end
    tick();
    n_chk++; if ({cpl_valid, cpl_tag, cpl_timeout} !== {1'b1, 2'd0, 1'b1} || busy_tags !== 4'b0000) begin n_fail++; $display("FAIL col_to_next: got %b busy %b want 1001 0000", {cpl_valid, cpl_tag, cpl_timeout}, busy_tags); end
  endtask

  task automatic test_serialising();
    do_reset();
    drive(CMD_ADD, 4'd1, 4'd2, 4'd3);   tick();
    drive(CMD_ADD, 4'd4, 4'd5, 4'd6);   tick();
    drive(CMD_ADD, 4'd7, 4'd8, 4'd9);   tick();
    idle();
    out_resp = RESP_OK; out_tag = 2'd0;
    tick();
    out_resp = RESP_NONE;
    drive(CMD_BRZ, 4'd0, 4'd0, 4'd0);
    #1;
    n_chk++; if (host_ready !== 1'b0 || busy_tags !== 4'b0110) begin n_fail++; $display("FAIL ser_wait: got ready %b busy %b want 0 0110", host_ready, busy_tags); end
    out_resp = RESP_OK; out_tag = 2'd1;
    tick();
    n_chk++; if (req_cmd !== 4'd0 || host_ready !== 1'b0) begin n_fail++; $display("FAIL ser_still: got cmd %0d ready %b want 0 0", req_cmd, host_ready); end
    out_tag = 2'd2;
    tick();
    out_resp = RESP_NONE;
    n_chk++; if (req_cmd !== 4'd0 || busy_tags !== 4'b0000) begin n_fail++; $display("FAIL ser_drain: got cmd %0d busy %b want 0 0000", req_cmd, busy_tags); end
    tick();
    n_chk++; if ({req_cmd, req_tag} !== {4'd12, 2'd0}) begin n_fail++; $display("FAIL ser_issue: got %h want %h", {req_cmd, req_tag}, {4'd12, 2'd0}); end
    drive(CMD_ADD, 4'd1, 4'd2, 4'd3);
    tick();
    n_chk++; if (req_cmd !== 4'd0 || host_ready !== 1'b0 || busy_tags !== 4'b0001) begin n_fail++; $display("FAIL ser_alone: got cmd %0d ready %b busy %b want 0 0 0001", req_cmd, host_ready, busy_tags); end
    out_resp = RESP_OK; out_tag = 2'd0;
    tick();
    out_resp = RESP_NONE;
    tick();
    idle();
    n_chk++; if ({req_cmd, req_tag} !== {4'd1, 2'd0}) begin n_fail++; $display("FAIL ser_after: got %h want %h", {req_cmd, req_tag}, {4'd1, 2'd0}); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    drive(CMD_STORE, 4'd0, 4'd0, 4'd7);
    tick();
    idle();
    n_chk++; if ({req_cmd, busy_tags} !== {4'd9, 4'b0001}) begin n_fail++; $display("FAIL mid_issue: got %h want 91", {req_cmd, busy_tags}); end
    #1 reset = 1'b1;
    #1;
    n_chk++; if ({req_cmd, req_r1, req_data, busy_tags, cpl_valid, spurious_err} !== 50'd0) begin n_fail++; $display("FAIL mid_async_clear: got %h want 0", {req_cmd, req_r1, req_data, busy_tags, cpl_valid, spurious_err}); end
    tick();
    reset = 1'b0;
    drive(CMD_ADD, 4'd1, 4'd2, 4'd3);
    tick();
    idle();
    n_chk++; if ({req_cmd, req_tag} !== {4'd1, 2'd0}) begin n_fail++; $display("FAIL mid_tag0: got %h want %h", {req_cmd, req_tag}, {4'd1, 2'd0}); end
    out_resp = RESP_OK; out_tag = 2'd1;
    tick();
    out_resp = RESP_NONE;
    n_chk++; if (spurious_err !== 1'b1 || busy_tags !== 4'b0001) begin n_fail++; $display("FAIL mid_late_resp: got spur %b busy %b want 1 0001", spurious_err, busy_tags); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_hazard();
    test_tag_full();
    test_timeout();
    test_collision();
    test_serialising();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/calc3_port_sched.md
Name: calc3_port_sched

Overview:
- Per-port issue controller for the calc3 arithmetic unit; four instances, one per request port 1..4.
- Accepts host commands over a valid/ready handshake and allocates a free 2-bit tag.
- Blocks on register hazards against in-flight operations, then drives the calc3 req*_ lines for exactly one cycle.
- Matches out*_resp/out*_tag responses back to tags and produces one completion per cycle; hung tags are retired by timeout.

Parameters:
- NUM_TAGS, 4, number of tags tracked; fixed by the 2-bit tag width, values other than 4 unsupported.
- TIMEOUT, 64, cycles from issue after which an outstanding tag is force-retired; legal range 2..1023.
- HAZARD_CHECK, 1, 1 = register scoreboard stalls enabled, 0 = issue whenever a tag is free.

Ports:
- c_clk  in  1  functional clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- host_valid  in  1  host command valid.
- host_ready  out  1  block can accept this cycle.
- host_cmd  in  4  calc3 command code.
- host_d1, host_d2, host_r1  in  4 each  operand and destination register numbers.
- host_data  in  32  store data.
- req_cmd  out  4  to calc3 reqN_cmd.
- req_d1, req_d2, req_r1  out  4 each  to reqN_d1/d2/r1.
- req_data  out  32  to reqN_data.
- req_tag  out  2  to reqN_tag.
- out_resp  in  2  from calc3 outN_resp; 0 = none.
- out_tag  in  2  from outN_tag.
- out_data  in  32  from outN_data.
- cpl_valid  out  1  one-cycle completion strobe.
- cpl_tag  out  2  completed tag.
- cpl_resp  out  2  calc3 response code; 0 when timed out.
- cpl_data  out  32  response data.
- cpl_timeout  out  1  completion caused by timeout.
- busy_tags  out  4  outstanding-tag bitmap.
- spurious_err  out  1  sticky: response arrived for a non-busy tag.

Behaviour:
- Reset (async): all req_*, cpl_*, busy_tags and spurious_err = 0; all timers cleared; in-flight operations are dropped silently, and late DUT responses after reset raise spurious_err.
- Accept: occurs when host_valid && host_ready at edge N. host_ready is combinational from registered state only and must not depend on host_valid.
- host_ready = a free tag exists && no hazard && no serialising operation outstanding && !(serialising command && busy_tags != 0).
- Issue: a command accepted at edge N drives req_* registered from edge N through edge N+1. req_cmd returns to 0 after one cycle, and req_d*/r1/data/tag return to 0. Back-to-back accepts give back-to-back issues with no bubble.
- Tag allocation: lowest-numbered free tag; busy bit set at the accept edge.
- Command classes: add (1) and sub (2) read d1, d2 and write r1. Shift left/right (5/6) read d1, d2 and write r1. Store (9) writes r1. Fetch (10) reads d1. Branch (12) and all other codes are serialising.
- Hazard (HAZARD_CHECK=1): stall if any busy tag's destination equals a register the new op reads or writes. Scoreboard holds {valid, writes_r1, r1} per tag.
- Response: out_resp != 0 with busy out_tag at edge M gives cpl_valid at M+1 with tag, resp and data registered. The busy bit clears at edge M, so the tag is allocatable for an accept at edge M+1, not at M.
- Spurious response: non-busy out_tag sets spurious_err and is otherwise ignored.
- Timeout: a per-tag counter runs from issue. At TIMEOUT the tag requests retirement, giving cpl_valid with cpl_timeout=1, cpl_resp=0 and cpl_data=0, and the busy bit clears.
- Collisions: at most one completion per cycle, and a DUT response has priority. A pending timeout on another tag holds (counter saturates) and retires next free cycle, lowest tag first. If a response and a timeout hit the same tag in the same cycle, the response wins with cpl_timeout=0. A late response after a timeout raises spurious_err.
- Accept and free of different tags in the same cycle are both honoured.

Decomposition:
- Package calc3_sched_pkg holds: the command code constants (CMD_NOP=0, ADD=1, SUB=2, SHL=5, SHR=6, STORE=9, FETCH=10, BRZ=12); the response constants (RESP_NONE=0, RESP_OK=1, RESP_ERR=2); the tag_t/reg_t/data_t typedefs; a scoreboard entry struct; and a cmd_class function returning reads_d1/reads_d2/writes_r1/serialising.
- One sub-module, calc3_tag_scoreboard, holds the busy bitmap, destination registers, timers, allocation, hazard compare and retire arbitration. The top level holds the handshake, issue register and completion register.

Test Plan:
- Reset, then accept ADD d1=1 d2=2 r1=3 and SUB d1=4 d2=5 r1=6 on consecutive edges -> req_cmd=1 tag 0 then req_cmd=2 tag 1 on consecutive cycles; busy_tags=4'b0011.
- ADD r1=3 outstanding, then host FETCH d1=3 -> host_ready=0 until out_resp=1 out_tag=0; accept next cycle; cpl_valid with cpl_tag=0, cpl_resp=1.
- Four independent ADDs with no responses -> tags 0..3 issued, host_ready=0. out_resp=1 out_tag=2 -> fifth command issues with tag 2 one cycle later.
- One ADD, no response for 64 cycles -> cpl_valid with cpl_timeout=1, cpl_tag=0, cpl_resp=0; a later out_resp=1 out_tag=0 sets spurious_err.
- BRZ with tags 1,2 busy -> stalled until both complete, issued alone; no accept while it is outstanding.
- Reset asserted one cycle after issue with tag 0 busy -> all outputs 0 immediately; after deassert the next command gets tag 0.
